// File: rtl/l1_l2_request_arbiter.sv
// Round-robin arbiter from the icache/dcache miss queues and the store queue
// into a single registered, credit-limited L2 request packet.
module l1_l2_request_arbiter #(
    parameter int L2_CREDITS = 4,
    parameter int ADDR_WIDTH = 26,
    parameter int IDX_WIDTH  = 2,
    parameter int LINE_BITS  = 512,
    parameter int MASK_BITS  = 64
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  ic_dequeue_ready,
    input  logic [ADDR_WIDTH-1:0] ic_dequeue_addr,
    input  logic [IDX_WIDTH-1:0]  ic_dequeue_idx,
    output logic                  ic_dequeue_ack,
    input  logic                  dc_dequeue_ready,
    input  logic [ADDR_WIDTH-1:0] dc_dequeue_addr,
    input  logic [IDX_WIDTH-1:0]  dc_dequeue_idx,
    input  logic                  dc_dequeue_synchronized,
    output logic                  dc_dequeue_ack,
    input  logic                  sq_dequeue_ready,
    input  logic [ADDR_WIDTH-1:0] sq_dequeue_addr,
    input  logic [IDX_WIDTH-1:0]  sq_dequeue_idx,
    input  logic                  sq_dequeue_synchronized,
    input  logic                  sq_dequeue_flush,
    input  logic [LINE_BITS-1:0]  sq_dequeue_data,
    input  logic [MASK_BITS-1:0]  sq_dequeue_mask,
    output logic                  sq_dequeue_ack,
    output logic                  l2_request_valid,
    input  logic                  l2_request_ready,
    output logic [1:0]            l2_request_unit,
    output logic [2:0]            l2_request_type,
    output logic [IDX_WIDTH-1:0]  l2_request_idx,
    output logic [ADDR_WIDTH-1:0] l2_request_addr,
    output logic [LINE_BITS-1:0]  l2_request_data,
    output logic [MASK_BITS-1:0]  l2_request_mask,
    input  logic                  l2_credit_return,
    output logic [3:0]            credits_available
);

    localparam logic [3:0] CREDIT_MAX = 4'(L2_CREDITS);
    localparam logic [2:0] T_LOAD       = 3'd0;
    localparam logic [2:0] T_LOAD_SYNC  = 3'd1;
    localparam logic [2:0] T_STORE      = 3'd2;
    localparam logic [2:0] T_STORE_SYNC = 3'd3;
    localparam logic [2:0] T_FLUSH      = 3'd4;

    logic [2:0]            req;
    logic [1:0]            rr_ptr;
    logic [1:0]            winner;
    logic [1:0]            ptr_next;
    logic                  can_capture;
    logic                  capture;
    logic [2:0]            nxt_type;
    logic [IDX_WIDTH-1:0]  nxt_idx;
    logic [ADDR_WIDTH-1:0] nxt_addr;
    logic [LINE_BITS-1:0]  nxt_data;
    logic [MASK_BITS-1:0]  nxt_mask;

    assign req = {sq_dequeue_ready, dc_dequeue_ready, ic_dequeue_ready};

    // Capture needs a free output slot (empty or draining now) and a credit.
    assign can_capture = reset_n
                       && (!l2_request_valid || l2_request_ready)
                       && (credits_available != 4'd0);
    assign capture = can_capture && (|req);

    always_comb begin
        winner = 2'd0;
        unique case (rr_ptr)
            2'd1: winner = req[1] ? 2'd1 : (req[2] ? 2'd2 : 2'd0);
            2'd2: winner = req[2] ? 2'd2 : (req[0] ? 2'd0 : 2'd1);
            default: winner = req[0] ? 2'd0 : (req[1] ? 2'd1 : 2'd2);
        endcase
    end

    assign ptr_next = (winner == 2'd2) ? 2'd0 : winner + 2'd1;

    assign ic_dequeue_ack = capture && (winner == 2'd0);
    assign dc_dequeue_ack = capture && (winner == 2'd1);
    assign sq_dequeue_ack = capture && (winner == 2'd2);

    always_comb begin
        nxt_type = T_LOAD;
        nxt_idx  = ic_dequeue_idx;
        nxt_addr = ic_dequeue_addr;
        nxt_data = '0;
        nxt_mask = '0;
        unique case (winner)
            2'd1: begin
                nxt_type = dc_dequeue_synchronized ? T_LOAD_SYNC : T_LOAD;
                nxt_idx  = dc_dequeue_idx;
                nxt_addr = dc_dequeue_addr;
            end
            2'd2: begin
                nxt_idx  = sq_dequeue_idx;
                nxt_addr = sq_dequeue_addr;
                if (sq_dequeue_flush) begin
                    nxt_type = T_FLUSH;
                end else begin
                    nxt_type = sq_dequeue_synchronized ? T_STORE_SYNC : T_STORE;
                    nxt_data = sq_dequeue_data;
                    nxt_mask = sq_dequeue_mask;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            l2_request_valid <= 1'b0;
            l2_request_unit  <= '0;
            l2_request_type  <= '0;
            l2_request_idx   <= '0;
            l2_request_addr  <= '0;
            l2_request_data  <= '0;
            l2_request_mask  <= '0;
            rr_ptr           <= 2'd0;
        end else if (capture) begin
            l2_request_valid <= 1'b1;
            l2_request_unit  <= winner;
            l2_request_type  <= nxt_type;
            l2_request_idx   <= nxt_idx;
            l2_request_addr  <= nxt_addr;
            l2_request_data  <= nxt_data;
            l2_request_mask  <= nxt_mask;
            rr_ptr           <= ptr_next;
        end else if (l2_request_ready) begin
            l2_request_valid <= 1'b0;
        end
    end

    // Credits are consumed at capture so a held packet already owns one.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            credits_available <= CREDIT_MAX;
        end else begin
            unique case ({capture, l2_credit_return})
                2'b10: credits_available <= credits_available - 4'd1;
                2'b01: if (credits_available != CREDIT_MAX)
                    credits_available <= credits_available + 4'd1;
                default: ;
            endcase
        end
    end

`ifndef SYNTHESIS
    credit_overflow: assert property (@(posedge clk) disable iff (!reset_n)
        !(l2_credit_return && credits_available == CREDIT_MAX));
`endif

endmodule

// File: doc/l1_l2_request_arbiter.md
Name: l1_l2_request_arbiter

Overview:
Sits directly downstream of the instruction and data L1 load miss queues and the store queue. Accepts their dequeue requests through ready/ack handshakes and round-robin arbitrates among them. Formats the winner into one registered L2 request packet and enforces a credit limit on outstanding L2 requests. Output feeds the core's L2 interface.

Parameters:
L2_CREDITS, 4, max requests sent to L2 and not yet credited back (1..15)
ADDR_WIDTH, 26, cache line index width
IDX_WIDTH, 2, miss/store entry index width
LINE_BITS, 512, cache line data width
MASK_BITS, 64, byte-enable width (LINE_BITS/8)

Ports:
clk  in  1  clock
reset_n  in  1  asynchronous active-low reset
ic_dequeue_ready  in  1  icache miss queue has a request
ic_dequeue_addr  in  ADDR_WIDTH  icache miss line address
ic_dequeue_idx  in  IDX_WIDTH  icache miss entry index
ic_dequeue_ack  out  1  icache request consumed this cycle
dc_dequeue_ready  in  1  dcache miss queue has a request
dc_dequeue_addr  in  ADDR_WIDTH  dcache miss line address
dc_dequeue_idx  in  IDX_WIDTH  dcache miss entry index
dc_dequeue_synchronized  in  1  load-linked miss
dc_dequeue_ack  out  1  dcache request consumed this cycle
sq_dequeue_ready  in  1  store queue has a request
sq_dequeue_addr  in  ADDR_WIDTH  store line address
sq_dequeue_idx  in  IDX_WIDTH  store entry index
sq_dequeue_synchronized  in  1  store-conditional
sq_dequeue_flush  in  1  request is a line flush
sq_dequeue_data  in  LINE_BITS  store data
sq_dequeue_mask  in  MASK_BITS  byte enables
sq_dequeue_ack  out  1  store request consumed this cycle
l2_request_valid  out  1  packet valid
l2_request_ready  in  1  L2 accepts packet this cycle
l2_request_unit  out  2  0 icache, 1 dcache, 2 store queue
l2_request_type  out  3  0 LOAD, 1 LOAD_SYNC, 2 STORE, 3 STORE_SYNC, 4 FLUSH
l2_request_idx  out  IDX_WIDTH  source entry index
l2_request_addr  out  ADDR_WIDTH  line address
l2_request_data  out  LINE_BITS  store data (zero for loads)
l2_request_mask  out  MASK_BITS  byte enables (zero for loads)
l2_credit_return  in  1  one credit returned by L2 this cycle
credits_available  out  4  credits currently free

Behaviour:
- Reset (reset_n low, async): l2_request_valid=0, all packet fields 0, all acks 0, credits_available=L2_CREDITS, round-robin pointer selects icache first.
- Output register: one entry. can_capture = (!l2_request_valid || l2_request_ready) && credits_available != 0.
- Arbitration combinational: among ready sources, round-robin starting at pointer, order icache→dcache→store queue. When can_capture and any ready: assert exactly one *_dequeue_ack in that cycle for the winner (combinational, same cycle), load packet on next edge, pointer moves to source after winner. No capture → no ack, pointer unchanged.
- Acks never asserted for a source whose ready is low; at most one ack per cycle.
- Packet formation: icache → unit 0, type LOAD. dcache → unit 1, type LOAD_SYNC if synchronized else LOAD. store queue → unit 2, type FLUSH if flush (synchronized ignored, data/mask zeroed), else STORE_SYNC/STORE per synchronized. Load packets drive data and mask zero.
- Hold: while l2_request_valid && !l2_request_ready all fields stable.
- Send: l2_request_valid && l2_request_ready. If a new winner is captured same cycle, valid stays 1 with new packet (back-to-back, one packet per cycle peak); otherwise valid drops next cycle.
- Credits: decrement by 1 at capture (not send), increment on l2_credit_return; simultaneous capture and return → unchanged. Credits 0 → no capture, sources stall, packet already held still sends. Return while credits==L2_CREDITS is an assertion failure; count saturates.
- reset_n asserted mid-handshake drops valid immediately; in-flight packet discarded.

Test Plan:
- Single dcache load, addr 0x123, idx 2, ready=1 → dc ack 1 same cycle; next cycle valid=1, unit 1, type LOAD, idx 2, addr 0x123, data/mask 0; credits 4→3.
- All three ready continuously, l2_request_ready=1, credit returned each cycle → acks rotate ic, dc, sq, ic…; valid stays 1 with one packet per cycle.
- l2_request_ready=0 for 5 cycles with packet held → fields unchanged, no acks; ready=1 → send; next winner captured that same cycle.
- 4 captures without credit return → credits_available=0, fifth request unacked until l2_credit_return pulses, then captured next cycle.
- Store queue flush with synchronized=1, mask 0xFF → type FLUSH, data and mask 0; store with synchronized=1 → STORE_SYNC with given data/mask.
- reset_n pulsed low while valid=1 and ready=0 → valid 0 asynchronously, credits_available=4, pointer back at icache.
